// File: rtl/rect_fill_engine.sv
// rect_fill_engine: accepts filled-rectangle commands, clips them to the
// back buffer and streams one RGB332 pixel write per cycle in row-major order.
module rect_fill_engine #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 8
) (
  input  logic               axi_aclk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [9:0]         cmd_x0,
  input  logic [8:0]         cmd_y0,
  input  logic [9:0]         cmd_w,
  input  logic [8:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               hold,
  output logic               wea,
  output logic [ADDR_W-1:0]  addra,
  output logic [COLOR_W-1:0] dina,
  output logic               busy,
  output logic               done
);

  localparam logic [10:0]       WIDTH_E  = 11'(WIDTH);
  localparam logic [10:0]       HEIGHT_E = 11'(HEIGHT);
  localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

  state_t state, state_nxt;

  // Exclusive end coordinate clipped to the buffer edge; 11 bits so that
  // start+len never wraps back on-screen.
  function automatic logic [10:0] clip_end(input logic [10:0] start,
                                           input logic [10:0] len,
                                           input logic [10:0] lim);
    logic [10:0] s;
    s = start + len;
    return (s > lim) ? lim : s;
  endfunction

  // Latched command fields
  logic [9:0]         x0_r;
  logic [8:0]         y0_r;
  logic [9:0]         w_r;
  logic [8:0]         h_r;
  logic [COLOR_W-1:0] color_r;

  // Scan position and clipped bounds
  logic [9:0]         x_r;
  logic [8:0]         y_r;
  logic [ADDR_W-1:0]  row_base_r;
  logic [10:0]        xe_r;
  logic [10:0]        ye_r;

  logic               accept;
  logic [10:0]        xe_c;
  logic [10:0]        ye_c;
  logic               empty_c;
  logic [ADDR_W-1:0]  row_base_c;
  logic               last_col;
  logic               last_row;

  logic               cmd_ready_d;
  logic               wea_d;
  logic [ADDR_W-1:0]  addra_d;
  logic [COLOR_W-1:0] dina_d;
  logic               busy_d;
  logic               done_d;

  assign accept     = (state == IDLE) && cmd_valid && cmd_ready;
  assign xe_c       = clip_end({1'b0, x0_r}, {1'b0, w_r}, WIDTH_E);
  assign ye_c       = clip_end({2'b0, y0_r}, {2'b0, h_r}, HEIGHT_E);
  assign empty_c    = ({1'b0, x0_r} >= WIDTH_E) || ({2'b0, y0_r} >= HEIGHT_E) ||
                      (w_r == 10'd0) || (h_r == 9'd0);
  // Only used when y0 is on-screen, so truncation to ADDR_W is harmless.
  assign row_base_c = ADDR_W'(y0_r) * WIDTH_A;
  assign last_col   = ({1'b0, x_r} == (xe_r - 11'd1));
  assign last_row   = ({2'b0, y_r} == (ye_r - 11'd1));

  // State register
  always_ff @(posedge axi_aclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CLIP;
      CLIP: state_nxt = empty_c ? DONE : FILL;
      FILL: if (!hold && last_col && last_row) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    wea_d       = (state == FILL) && !hold;
    addra_d     = wea_d ? (row_base_r + ADDR_W'(x_r)) : addra;
    dina_d      = wea_d ? color_r : dina;
    done_d      = (state == DONE);
    busy_d      = (state == IDLE) ? accept : (state != DONE);
    cmd_ready_d = (state == IDLE) ? !accept : (state == DONE);
  end

  // Output registers
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      cmd_ready <= 1'b1;
      wea       <= 1'b0;
      addra     <= '0;
      dina      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_d;
      wea       <= wea_d;
      addra     <= addra_d;
      dina      <= dina_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Command latch, clip load and row-major scan advance (data only, no reset)
  always_ff @(posedge axi_aclk) begin
    if (accept) begin
      x0_r    <= cmd_x0;
      y0_r    <= cmd_y0;
      w_r     <= cmd_w;
      h_r     <= cmd_h;
      color_r <= cmd_color;
    end
    if (state == CLIP) begin
      x_r        <= x0_r;
      y_r        <= y0_r;
      row_base_r <= row_base_c;
      xe_r       <= xe_c;
      ye_r       <= ye_c;
    end else if (state == FILL && !hold) begin
      if (last_col) begin
        x_r        <= x0_r;
        row_base_r <= row_base_r + WIDTH_A;
        if (!last_row) y_r <= y_r + 9'd1;
      end else begin
        x_r <= x_r + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Testbench for rect_fill_engine: directed and random rectangle commands
// checked against a coordinate-level reference model.
module tb_rect_fill_engine;

  localparam int W = 320;
  localparam int H = 240;

  logic        axi_aclk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x0 = '0;
  logic [8:0]  cmd_y0 = '0;
  logic [9:0]  cmd_w = '0;
  logic [8:0]  cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic        hold = 1'b0;
  logic        wea;
  logic [16:0] addra;
  logic [7:0]  dina;
  logic        busy;
  logic        done;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int over_cnt = 0;
  int wr_a[$];
  int wr_d[$];
  int wr_c[$];
  bit hpat[64];

  rect_fill_engine #(.WIDTH(320), .HEIGHT(240), .ADDR_W(17), .COLOR_W(8)) dut (
    .axi_aclk (axi_aclk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0   (cmd_x0),
    .cmd_y0   (cmd_y0),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .hold     (hold),
    .wea      (wea),
    .addra    (addra),
    .dina     (dina),
    .busy     (busy),
    .done     (done)
  );

  always #5 axi_aclk = ~axi_aclk;

  always @(posedge axi_aclk) cyc <= cyc + 1;

  // Write/done monitor, sampled on the falling edge
  always @(negedge axi_aclk) begin
    if (wea === 1'b1) begin
      wr_a.push_back(int'(addra));
      wr_d.push_back(int'(dina));
      wr_c.push_back(cyc);
      if (int'(addra) >= W * H) over_cnt++;
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_hold();
    foreach (hpat[i]) hpat[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  // Issue one command and check its writes, ordering, timing and done pulse.
  // hpat[k] drives hold for the edge k+1 cycles after the accept edge.
  task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                         input int col, input string tag);
    int exp_a[$];
    int exp_c[$];
    int cnt, e, n, acc, t, exp_done, nbad;
    int xend, yend;
    bit got;
    // reference model: clipped rectangle in row-major order
    xend = (x0 + w < W) ? x0 + w : W;
    yend = (y0 + h < H) ? y0 + h : H;
    for (int yy = y0; yy < yend; yy++)
      for (int xx = x0; xx < xend; xx++)
        exp_a.push_back(yy * W + xx);
    cnt = exp_a.size();
    // timing model: writes start 2 edges after accept, each held edge stalls one
    e = 2;
    n = 0;
    while (n < cnt) begin
      if (e - 1 < 64 && hpat[e-1]) e++;
      else begin
        exp_c.push_back(e);
        n++;
        e++;
      end
    end
    exp_done = e;

    t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk({tag, "_ready"}, cmd_ready, 1);

    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
    cmd_x0 = 10'(x0);
    cmd_y0 = 9'(y0);
    cmd_w = 10'(w);
    cmd_h = 9'(h);
    cmd_color = 8'(col);
    cmd_valid = 1'b1;
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
    cmd_x0 = 10'($urandom);
    cmd_y0 = 9'($urandom);
    cmd_w = 10'($urandom);
    cmd_h = 9'($urandom);
    cmd_color = 8'($urandom);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_notready"}, cmd_ready, 0);

    got = 1'b0;
    for (int k = 0; k < cnt + 100 && !got; k++) begin
      hold = (k < 64) ? hpat[k] : 1'b0;
      tick();
      if (done === 1'b1) got = 1'b1;
    end
    hold = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_done_lat"}, cyc - acc, exp_done);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_count"}, wr_a.size(), cnt);
    nbad = 0;
    for (int i = 0; i < cnt && i < wr_a.size(); i++) begin
      bit diff;
      diff = (wr_a[i] != exp_a[i]) || (wr_d[i] != col) || (wr_c[i] - acc != exp_c[i]);
      if (i < 8 || (diff && nbad < 8)) begin
        chk($sformatf("%s_addr%0d", tag, i), wr_a[i], exp_a[i]);
        chk($sformatf("%s_data%0d", tag, i), wr_d[i], col);
        chk($sformatf("%s_when%0d", tag, i), wr_c[i] - acc, exp_c[i]);
        if (diff) nbad++;
      end
    end
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int acc, d0;
    clear_hold();
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_wea", wea, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick();

    run_cmd(5, 2, 1, 1, 8'hE0, "single");
    run_cmd(10, 10, 3, 2, 8'h1C, "rect");
    run_cmd(318, 238, 10, 10, 8'h03, "edge");
    run_cmd(0, 0, 0, 5, 8'h11, "deg_w0");
    run_cmd(320, 0, 5, 5, 8'h22, "deg_x320");
    run_cmd(0, 300, 5, 5, 8'h33, "deg_y300");
    run_cmd(1023, 5, 1023, 3, 8'h44, "ovf_x");
    run_cmd(5, 239, 2, 511, 8'h55, "clip_h");

    hpat[3] = 1'b1;
    hpat[4] = 1'b1;
    hpat[5] = 1'b1;
    run_cmd(100, 50, 4, 1, 8'hA5, "hold");
    clear_hold();

    for (int r = 0; r < 20; r++) begin
      int rx, ry, rw, rh;
      rx = $urandom_range(0, 339);
      ry = $urandom_range(0, 255);
      rw = $urandom_range(0, 12);
      rh = $urandom_range(0, 8);
      if ($urandom_range(0, 7) == 0) begin
        rx = 1023;
        rw = 1023;
      end
      foreach (hpat[i]) hpat[i] = ($urandom_range(0, 3) == 0);
      run_cmd(rx, ry, rw, rh, $urandom_range(0, 255), $sformatf("rnd%0d", r));
    end
    clear_hold();

    run_cmd(0, 0, 320, 240, 8'hFF, "clear");
    chk("clear_last_addr", (wr_a.size() > 0) ? wr_a[wr_a.size()-1] : -1, W * H - 1);

    // full clear abandoned by reset after 1000 writes
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
    d0 = done_cnt;
    cmd_x0 = 10'd0;
    cmd_y0 = 9'd0;
    cmd_w = 10'd320;
    cmd_h = 9'd240;
    cmd_color = 8'h77;
    cmd_valid = 1'b1;
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
    while (cyc - acc < 1001) tick();
    reset = 1'b1;
    tick();
    chk("rstmid_wea", wea, 0);
    chk("rstmid_ready", cmd_ready, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    reset = 1'b0;
    repeat (5) tick();
    chk("rstmid_writes", wr_a.size(), 1000);
    chk("rstmid_no_done", done_cnt, d0);
    run_cmd(7, 3, 1, 1, 8'h5A, "after_rst");

    chk("addr_in_range", over_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
